// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: register file geometry,
// address type and the default in-flight limit.
package hazard_scoreboard_pkg;

  localparam int unsigned NUM_REGS            = 32;
  localparam int unsigned MAX_OUTSTANDING_DEF = 2;
  // Sized for the whole register file so the count can never wrap.
  localparam int unsigned CNT_W               = $clog2(NUM_REGS + 1);

  typedef logic [4:0] reg_addr_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks pending long-latency register writes and stalls the ID stage on
// RAW, WAW and capacity hazards; writebacks in flight are bypassed.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  reg_addr_t   id_rs1_addr_i,
  input  reg_addr_t   id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  reg_addr_t   id_rd_addr_i,
  input  logic        id_write_rd_i,
  input  logic        id_long_lat_i,
  input  logic        ex_ready_i,
  input  logic        flush_i,
  input  logic        wb_done_i,
  input  reg_addr_t   wb_rd_addr_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] pending_o,
  output logic [31:0] stall_cycles_o,
  output logic        err_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d, busy_mask;
  logic [CNT_W-1:0]    count_q;
  logic                err_q;
  logic                wb_hit, set_en, issue;
  logic                raw1, raw2, waw, cap;

  // Bit 0 of pending_q is never set, so a writeback to x0 is never a hit.
  always_comb begin
    wb_hit    = wb_done_i && pending_q[wb_rd_addr_i];
    busy_mask = pending_q & ~(wb_done_i ? reg_onehot(wb_rd_addr_i) : '0);
    raw1      = id_rs1_used_i && (id_rs1_addr_i != '0) && busy_mask[id_rs1_addr_i];
    raw2      = id_rs2_used_i && (id_rs2_addr_i != '0) && busy_mask[id_rs2_addr_i];
    waw       = id_write_rd_i && (id_rd_addr_i != '0) && busy_mask[id_rd_addr_i];
    cap       = id_long_lat_i && id_write_rd_i && !wb_done_i &&
                (count_q == CNT_W'(MAX_OUTSTANDING));
    stall_o   = id_valid_i && (raw1 || raw2 || waw || cap);
    issue     = id_valid_i && ex_ready_i && !stall_o && !flush_i;
    set_en    = issue && id_long_lat_i && id_write_rd_i && (id_rd_addr_i != '0);
  end

  // Clear before set so a same-cycle set/clear of one register leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_hit) pending_d[wb_rd_addr_i] = 1'b0;
    if (set_en) pending_d[id_rd_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case ({set_en, wb_hit})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (wb_done_i && !wb_hit) err_q <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (stall_o),
    .count_o (stall_cycles_o)
  );

  assign busy_o    = (count_q != '0);
  assign pending_o = pending_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus random
// traffic checked against a set-based reference model.
module tb_hazard_scoreboard;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_rs1_used, id_rs2_used, id_write_rd, id_long_lat;
  logic        ex_ready, flush, wb_done;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
  logic        stall, busy, err;
  logic [31:0] pending, stall_cycles;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_rs1_used_i  (id_rs1_used),
    .id_rs2_used_i  (id_rs2_used),
    .id_rd_addr_i   (id_rd_addr),
    .id_write_rd_i  (id_write_rd),
    .id_long_lat_i  (id_long_lat),
    .ex_ready_i     (ex_ready),
    .flush_i        (flush),
    .wb_done_i      (wb_done),
    .wb_rd_addr_i   (wb_rd_addr),
    .stall_o        (stall),
    .busy_o         (busy),
    .pending_o      (pending),
    .stall_cycles_o (stall_cycles),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, v, u1, u2, wr, ll, rdy, fl, wb;
    bit [4:0] rs1, rs2, rd, wa;
  } stim_t;

  typedef struct {
    bit        stall, busy, err;
    bit [31:0] pend, sc;
  } exp_t;

  exp_t      expq[$];
  int        n_cmp = 0, n_bad = 0;
  bit        stim_done = 1'b0;

  // Reference state: the set of registers awaiting writeback.
  bit [31:0] m_pend = '0;
  bit [31:0] m_sc   = '0;
  bit        m_err  = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t op(input bit [4:0] rd, input bit ll);
    stim_t s;
    s = idle();
    s.v = 1'b1; s.rd = rd; s.wr = 1'b1; s.ll = ll;
    return s;
  endfunction

  task automatic cyc(input stim_t s);
    exp_t e;
    bit   stl, iss, hit;
    int   cnt;
    @(posedge clk); #1;
    rst = s.rst; id_valid = s.v; id_rs1_addr = s.rs1; id_rs2_addr = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2; id_rd_addr = s.rd;
    id_write_rd = s.wr; id_long_lat = s.ll; ex_ready = s.rdy; flush = s.fl;
    wb_done = s.wb; wb_rd_addr = s.wa;
    cnt = $countones(m_pend);
    // A register whose result is being written back right now is forwarded.
    stl = s.v && (
            (s.u1 && s.rs1 != 0 && m_pend[s.rs1] && !(s.wb && s.wa == s.rs1)) ||
            (s.u2 && s.rs2 != 0 && m_pend[s.rs2] && !(s.wb && s.wa == s.rs2)) ||
            (s.wr && s.rd  != 0 && m_pend[s.rd]  && !(s.wb && s.wa == s.rd))  ||
            (s.ll && s.wr && cnt == int'(MAXO) && !s.wb));
    e.stall = stl; e.busy = (cnt != 0); e.pend = m_pend; e.sc = m_sc; e.err = m_err;
    expq.push_back(e);
    iss = s.v && s.rdy && !stl && !s.fl;
    hit = s.wb && s.wa != 0 && m_pend[s.wa];
    if (s.rst) begin
      m_pend = '0; m_sc = '0; m_err = 1'b0;
    end else begin
      if (s.wb && !hit) m_err = 1'b1;
      if (hit) m_pend[s.wa] = 1'b0;
      if (iss && s.ll && s.wr && s.rd != 0) m_pend[s.rd] = 1'b1;
      if (stl && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    end
  endtask

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("stall",        {31'd0, stall}, {31'd0, e.stall});
        check("busy",         {31'd0, busy},  {31'd0, e.busy});
        check("pending",      pending,        e.pend);
        check("stall_cycles", stall_cycles,   e.sc);
        check("err",          {31'd0, err},   {31'd0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    rst = 1'b1; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0;
    id_rs2_used = 0; id_rd_addr = 0; id_write_rd = 0; id_long_lat = 0;
    ex_ready = 1; flush = 0; wb_done = 0; wb_rd_addr = 0;

    // Reset, then clean idle outputs.
    s = idle(); s.rst = 1'b1; cyc(s); cyc(s);
    cyc(idle()); cyc(idle());

    // Load-use on x5: three stalled cycles, released by the writeback.
    cyc(op(5, 1));
    s = idle(); s.v = 1; s.rs1 = 5; s.u1 = 1;
    repeat (3) cyc(s);
    s.wb = 1; s.wa = 5; cyc(s);
    cyc(idle());

    // WAW stall, then reissue to x7 colliding with its own writeback.
    cyc(op(7, 1));
    cyc(op(7, 1));
    s = op(7, 1); s.wb = 1; s.wa = 7; cyc(s);
    cyc(idle());
    s = idle(); s.wb = 1; s.wa = 7; cyc(s);

    // Capacity: x1,x2 in flight block x3 unless a writeback happens now.
    cyc(op(1, 1)); cyc(op(2, 1));
    cyc(op(3, 1));
    s = op(3, 1); s.wb = 1; s.wa = 1; cyc(s);
    cyc(idle());
    s = idle(); s.wb = 1; s.wa = 2; cyc(s);
    s.wa = 3; cyc(s);

    // x0 destination and flushed op are both ignored.
    cyc(op(0, 1));
    s = op(9, 1); s.fl = 1; cyc(s);
    cyc(idle());

    // Spurious writeback sets sticky err; x0 writeback likewise; reset clears.
    s = idle(); s.wb = 1; s.wa = 12; cyc(s);
    cyc(idle()); cyc(idle());
    cyc(op(6, 1));
    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.wb = 1; s.wa = 6; cyc(s);
    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.wb = 1; s.wa = 0; cyc(s);
    s = idle(); s.rst = 1; cyc(s);
    cyc(idle());

    // Saturation: preload the stall counter near its ceiling.
    cyc(op(4, 1));
    @(negedge clk); #1;
    force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count_q;
    m_sc = 32'hFFFF_FFFE;
    s = idle(); s.v = 1; s.rs2 = 4; s.u2 = 1;
    repeat (3) cyc(s);
    s.wb = 1; s.wa = 4; cyc(s);
    s = idle(); s.rst = 1; cyc(s);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      int unsigned cand[$];
      s.rst = ($urandom_range(0, 199) == 0);
      s.v   = ($urandom_range(0, 9) < 8);
      s.rs1 = 5'($urandom_range(0, 7)); s.u1 = $urandom_range(0, 1) == 1;
      s.rs2 = 5'($urandom_range(0, 7)); s.u2 = $urandom_range(0, 1) == 1;
      s.rd  = 5'($urandom_range(0, 7)); s.wr = ($urandom_range(0, 9) < 8);
      s.ll  = $urandom_range(0, 1) == 1;
      s.rdy = ($urandom_range(0, 9) < 8);
      s.fl  = ($urandom_range(0, 19) == 0);
      s.wb  = ($urandom_range(0, 9) < 4);
      cand.delete();
      for (int unsigned r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 9) < 9)
        s.wa = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        s.wa = 5'($urandom_range(0, 7));
      cyc(s);
    end

    repeat (3) @(negedge clk);
    stim_done = 1'b1;
    if (expq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
